// File: rtl/nc_array_pkg.sv
// Shared definitions for the systolic array front end: default geometry,
// west feeder state encoding and the row slice helper.
package nc_array_pkg;

    localparam int NC_ROWS   = 4;
    localparam int NC_DATA_W = 32;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_STREAM = 2'd1,
        FS_DRAIN  = 2'd2,
        FS_DONE   = 2'd3
    } feeder_state_e;

    // Bit offset of row 'row' inside a packed row-major vector.
    function automatic int row_lsb(input int row, input int width);
        return row * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift line carrying one west-edge row plus its valid flag;
// DEPTH registers including the output register.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    input  logic              dv,
    output logic [DATA_W-1:0] q,
    output logic              qv
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i]  = '0;
            valid_d[i] = 1'b0;
        end
        if (!clear) begin
            data_d[0]  = d;
            valid_d[0] = dv;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q  = data_q[DEPTH-1];
    assign qv = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_west_feeder.sv
// Accepts one activation vector per cycle and presents it skewed on the
// array west edge (row r delayed r cycles), with compute enable and tile done.
module systolic_west_feeder
    import nc_array_pkg::*;
#(
    parameter int ROWS   = NC_ROWS,
    parameter int DATA_W = NC_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [ROWS*DATA_W-1:0] west_data,
    output logic [ROWS-1:0]        west_valid,
    output logic                   compute,
    output logic                   busy,
    output logic                   done
);

    localparam int              CNT_W      = $clog2(ROWS) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((ROWS > 1) ? ROWS - 2 : 0);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             compute_q, compute_d;
    logic             done_q, done_d;
    logic             armed_q;
    logic             accept;

    // done_q marks the first IDLE cycle after DONE; the tile is still
    // leaving the array then, so no new beat is taken in that cycle.
    assign in_ready = armed_q && !done_q && !clear &&
                      ((state_q == FS_IDLE) || (state_q == FS_STREAM));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            FS_IDLE, FS_STREAM: begin
                if (accept) begin
                    drain_cnt_d = '0;
                    if (!in_last) begin
                        state_d = FS_STREAM;
                    end else if (ROWS > 1) begin
                        state_d = FS_DRAIN;
                    end else begin
                        state_d = FS_DONE;
                    end
                end
            end
            FS_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = FS_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            FS_DONE: state_d = FS_IDLE;
            default: state_d = FS_IDLE;
        endcase
        if (clear) begin
            state_d     = FS_IDLE;
            drain_cnt_d = '0;
        end
    end

    assign compute_d = !clear && (accept || (state_q == FS_STREAM) || (state_q == FS_DRAIN));
    assign done_d    = !clear && (state_q == FS_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_IDLE;
            drain_cnt_q <= '0;
            compute_q   <= 1'b0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            compute_q   <= compute_d;
            done_q      <= done_d;
            armed_q     <= 1'b1;
        end
    end

    assign compute = compute_q;
    assign done    = done_q;
    assign busy    = (state_q != FS_IDLE);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_W-1:0] row_in;

        assign row_in = accept ? in_data[row_lsb(r, DATA_W) +: DATA_W] : '0;

        skew_delay_line #(
            .DEPTH  (r + 1),
            .DATA_W (DATA_W)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .d     (row_in),
            .dv    (accept),
            .q     (west_data[row_lsb(r, DATA_W) +: DATA_W]),
            .qv    (west_valid[r])
        );
    end

endmodule
